// File: rtl/ula_seq_param_if.sv
// ----------------------------------------------------------------------------
// ula_seq_param_if
// Purpose : Handshake bundle between the register-file side (producer of
//           operations) and the write-back side (consumer of results) of the
//           sequential ULA.
// Signals : in_valid/in_ready  operation handshake (A, B, seletor, carry_in)
//           out_valid/out_ready result handshake (resultado + status flags)
// Modports: master - the side that issues operations and consumes results
//           slave  - the ULA itself
// ----------------------------------------------------------------------------
interface ula_seq_param_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       seletor;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] resultado;
  logic             carry_out;
  logic             overflow;
  logic             zero;
  logic             negativo;
  logic             gerado;
  logic             propagado;

  modport master (
    output in_valid, A, B, seletor, carry_in, out_ready,
    input  in_ready, out_valid, resultado, carry_out, overflow,
           zero, negativo, gerado, propagado
  );

  modport slave (
    input  in_valid, A, B, seletor, carry_in, out_ready,
    output in_ready, out_valid, resultado, carry_out, overflow,
           zero, negativo, gerado, propagado
  );
endinterface

// File: rtl/ula_seq_param.sv
// ----------------------------------------------------------------------------
// ula_seq_param
// Purpose : Registered, width-parametrised ULA with valid/ready handshakes.
//           Logic ops, ADD and SUB complete in one cycle; MUL is a shift-add
//           multiplier taking WIDTH cycles. Result and status flags are held
//           in registers until the consumer accepts them.
// Ports   : clk    - single clock, rising edge
//           reset  - synchronous, active-high, overrides everything
//           bus    - ula_seq_param_if.slave (operands in, result/flags out)
// Ops     : 000 A&B  001 A|B  010 ~A  011 ~(A&B)
//           100 A+B+cin  101 A-B  110 A*B (low half)  111 A^B
// ----------------------------------------------------------------------------
module ula_seq_param #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             reset,
  ula_seq_param_if.slave  bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Flag helper: result is all zeros.
  function automatic logic is_zero(input logic [WIDTH-1:0] value);
    return (value == {WIDTH{1'b0}});
  endfunction

  state_t             state_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      count_r;

  logic               out_valid_r;
  logic [WIDTH-1:0]   resultado_r;
  logic               carry_out_r;
  logic               overflow_r;
  logic               zero_r;
  logic               negativo_r;
  logic               gerado_r;
  logic               propagado_r;

  logic               in_ready_s;
  logic               accept_s;
  logic [WIDTH:0]     gsum_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH-1:0]   bop_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_cout_s;
  logic               alu_ovf_s;
  logic               alu_gen_s;
  logic               alu_prop_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic               mul_last_s;

  // Ready while idle, or while the held result is being taken this cycle.
  always_comb begin
    in_ready_s = (state_r == IDLE) | ((state_r == DONE) & bus.out_ready);
    accept_s   = bus.in_valid & in_ready_s;
  end

  // Single-cycle datapath: result and flags for every op except MUL.
  always_comb begin
    // Plain A+B without carry_in gives the group generate term.
    gsum_s     = {1'b0, bus.A} + {1'b0, bus.B};
    sum_s      = {(WIDTH+1){1'b0}};
    bop_s      = bus.B;
    alu_res_s  = {WIDTH{1'b0}};
    alu_cout_s = 1'b0;
    alu_ovf_s  = 1'b0;
    alu_gen_s  = 1'b0;
    alu_prop_s = 1'b0;
    case (bus.seletor)
      OP_AND:  alu_res_s = bus.A & bus.B;
      OP_OR:   alu_res_s = bus.A | bus.B;
      OP_NOT:  alu_res_s = ~bus.A;
      OP_NAND: alu_res_s = ~(bus.A & bus.B);
      OP_ADD: begin
        bop_s      = bus.B;
        sum_s      = gsum_s + {{WIDTH{1'b0}}, bus.carry_in};
        alu_res_s  = sum_s[WIDTH-1:0];
        alu_cout_s = sum_s[WIDTH];
        alu_ovf_s  = (bus.A[WIDTH-1] == bop_s[WIDTH-1]) &
                     (alu_res_s[WIDTH-1] != bus.A[WIDTH-1]);
        alu_gen_s  = gsum_s[WIDTH];
        alu_prop_s = &(bus.A ^ bus.B);
      end
      OP_SUB: begin
        // Two's complement subtract; carry_in is deliberately not used.
        bop_s      = ~bus.B;
        sum_s      = {1'b0, bus.A} + {1'b0, bop_s} + {{WIDTH{1'b0}}, 1'b1};
        alu_res_s  = sum_s[WIDTH-1:0];
        alu_cout_s = sum_s[WIDTH];
        alu_ovf_s  = (bus.A[WIDTH-1] == bop_s[WIDTH-1]) &
                     (alu_res_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_XOR:  alu_res_s = bus.A ^ bus.B;
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_next_s = acc_r + (mplier_r[0] ? mcand_r : {(2*WIDTH){1'b0}});
    mul_last_s = (count_r == LAST_CNT);
  end

  // Control FSM plus all result/flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      acc_r       <= {(2*WIDTH){1'b0}};
      mcand_r     <= {(2*WIDTH){1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      count_r     <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      resultado_r <= {WIDTH{1'b0}};
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
      negativo_r  <= 1'b0;
      gerado_r    <= 1'b0;
      propagado_r <= 1'b0;
    end else if (accept_s) begin
      // Accept from IDLE or from DONE in the cycle the result is consumed.
      if (bus.seletor == OP_MUL) begin
        mcand_r     <= {{WIDTH{1'b0}}, bus.A};
        mplier_r    <= bus.B;
        acc_r       <= {(2*WIDTH){1'b0}};
        count_r     <= {CW{1'b0}};
        out_valid_r <= 1'b0;
        state_r     <= EXEC;
      end else begin
        resultado_r <= alu_res_s;
        carry_out_r <= alu_cout_s;
        overflow_r  <= alu_ovf_s;
        zero_r      <= is_zero(alu_res_s);
        negativo_r  <= alu_res_s[WIDTH-1];
        gerado_r    <= alu_gen_s;
        propagado_r <= alu_prop_s;
        out_valid_r <= 1'b1;
        state_r     <= DONE;
      end
    end else begin
      case (state_r)
        IDLE: state_r <= IDLE;
        EXEC: begin
          acc_r    <= acc_next_s;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          count_r  <= count_r + CNT_ONE;
          if (mul_last_s) begin
            resultado_r <= acc_next_s[WIDTH-1:0];
            carry_out_r <= 1'b0;
            overflow_r  <= |acc_next_s[2*WIDTH-1:WIDTH];
            zero_r      <= is_zero(acc_next_s[WIDTH-1:0]);
            negativo_r  <= acc_next_s[WIDTH-1];
            gerado_r    <= 1'b0;
            propagado_r <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= EXEC;
          end
        end
        DONE: begin
          // Hold everything until the consumer takes the result.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.resultado = resultado_r;
  assign bus.carry_out = carry_out_r;
  assign bus.overflow  = overflow_r;
  assign bus.zero      = zero_r;
  assign bus.negativo  = negativo_r;
  assign bus.gerado    = gerado_r;
  assign bus.propagado = propagado_r;

endmodule
